kmeans_point_store: RTL and testbench

KMEANS_POINT_STORE -- requirements
Module: kmeans_point_store

---
 rtl/kmeans_point_store_if.sv | 44 ++++
 rtl/kmeans_point_store.sv | 135 +++++++++++++
 tb/tb_kmeans_point_store.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kmeans_point_store_if.sv
// Point-store bus: load handshake, read port, label write port, change counter.
interface kmeans_point_store_if #(
  parameter int CW = 8,
  parameter int LW = 3,
  parameter int AW = 6
);
  logic          ld_valid;
  logic          ld_ready;
  logic [CW-1:0] ld_x;
  logic [CW-1:0] ld_y;
  logic [CW-1:0] ld_z;
  logic          loaded;
  logic [AW-1:0] raddr;
  logic          rd_en;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic [CW-1:0] z;
  logic [LW-1:0] label;
  logic          lvalid;
  logic          rvalid;
  logic          we;
  logic [AW-1:0] waddr;
  logic [LW-1:0] wlabel;
  logic          pass_clr;
  logic [AW:0]   changes;

  modport master (
    output ld_valid, ld_x, ld_y, ld_z,
    output raddr, rd_en,
    output we, waddr, wlabel, pass_clr,
    input  ld_ready, loaded,
    input  x, y, z, label, lvalid, rvalid,
    input  changes
  );

  modport slave (
    input  ld_valid, ld_x, ld_y, ld_z,
    input  raddr, rd_en,
    input  we, waddr, wlabel, pass_clr,
    output ld_ready, loaded,
    output x, y, z, label, lvalid, rvalid,
    output changes
  );
endinterface

// File: rtl/kmeans_point_store.sv
// K-means point store: 3-axis coordinates plus per-point labels.
// Define KPS_CHANGE_CNT_EN to build the per-pass label-change counter.
module kmeans_point_store #(
  parameter int N  = 41,
  parameter int CW = 8,
  parameter int LW = 3,
  parameter int AW = 6
) (
  input logic                 clk,
  input logic                 rst_n,
  kmeans_point_store_if.slave bus
);

  localparam logic [AW:0]   NL   = (AW+1)'(N);
  localparam logic [AW-1:0] LAST = AW'(N-1);

  logic [CW-1:0] xm [N];
  logic [CW-1:0] ym [N];
  logic [CW-1:0] zm [N];
  logic [LW-1:0] lm [N];

  logic [N-1:0]  lv_q;
  logic [AW-1:0] wp_q;
  logic          loaded_q;
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic [CW-1:0] z_q;
  logic [LW-1:0] label_q;
  logic          lvalid_q;
  logic          rvalid_q;

  logic ld_acc;
  logic r_ok;
  logic w_ok;

  assign ld_acc = bus.ld_valid && !loaded_q;
  assign r_ok   = {1'b0, bus.raddr} < NL;
  assign w_ok   = bus.we && loaded_q &&
                  ({1'b0, bus.waddr} < NL);

  // Storage arrays are deliberately unreset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (ld_acc) begin
      xm[wp_q] <= bus.ld_x;
      ym[wp_q] <= bus.ld_y;
      zm[wp_q] <= bus.ld_z;
    end
    if (w_ok) begin
      lm[bus.waddr] <= bus.wlabel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q     <= '0;
      loaded_q <= 1'b0;
      lv_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      label_q  <= '0;
      lvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      if (ld_acc) begin
        if (wp_q == LAST) begin
          loaded_q <= 1'b1;
        end else begin
          wp_q <= wp_q + 1'b1;
        end
      end
      if (w_ok) begin
        lv_q[bus.waddr] <= 1'b1;
      end
      rvalid_q <= bus.rd_en;
      if (bus.rd_en) begin
        if (r_ok) begin
          x_q      <= xm[bus.raddr];
          y_q      <= ym[bus.raddr];
          z_q      <= zm[bus.raddr];
          label_q  <= lm[bus.raddr];
          lvalid_q <= lv_q[bus.raddr];
        end else begin
          x_q      <= '0;
          y_q      <= '0;
          z_q      <= '0;
          label_q  <= '0;
          lvalid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.ld_ready = !loaded_q;
  assign bus.loaded   = loaded_q;
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.z        = z_q;
  assign bus.label    = label_q;
  assign bus.lvalid   = lvalid_q;
  assign bus.rvalid   = rvalid_q;

`ifdef KPS_CHANGE_CNT_EN
  logic [AW:0] changes_q;
  logic [AW:0] changes_d;
  logic        counted;

  // Unlabelled points count as a change on their first write.
  always_comb begin
    counted   = w_ok && (!lv_q[bus.waddr] ||
                (lm[bus.waddr] != bus.wlabel));
    changes_d = changes_q;
    if (bus.pass_clr) begin
      changes_d = '0;
    end else if (counted && changes_q != NL) begin
      changes_d = changes_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changes_q <= '0;
    end else begin
      changes_q <= changes_d;
    end
  end

  assign bus.changes = changes_q;
`else
  logic unused_pass_clr;
  assign unused_pass_clr = bus.pass_clr;
  assign bus.changes     = '0;
`endif

endmodule

// File: tb/tb_kmeans_point_store.sv
// Randomized scoreboard bench for kmeans_point_store.
// Reads queue expectations from an array model; a negedge monitor checks them.
module tb_kmeans_point_store;
  localparam int N  = 41;
  localparam int CW = 8;
  localparam int LW = 3;
  localparam int AW = 6;

  logic clk;
  logic rst_n;

  kmeans_point_store_if #(.CW(CW), .LW(LW), .AW(AW)) bus ();

  kmeans_point_store #(.N(N), .CW(CW), .LW(LW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] z;
    logic [LW-1:0] l;
    logic          v;
    bit            cc;
    bit            cl;
  } rd_t;

  rd_t q[$];

  int tests = 0;
  int fails = 0;

  int mx [N];
  int my [N];
  int mz [N];
  int ml [N];
  bit mv [N];
  bit mk [N];
  int mwp;
  bit mld;
  int mch;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rvalid === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rvalid_unexpected: got 1 expected 0");
      end else begin
        rd_t e;
        e = q.pop_front();
        chk("rd_lvalid", 64'(bus.lvalid), 64'(e.v));
        if (e.cc) begin
          chk("rd_x", 64'(bus.x), 64'(e.x));
          chk("rd_y", 64'(bus.y), 64'(e.y));
          chk("rd_z", 64'(bus.z), 64'(e.z));
        end
        if (e.cl) chk("rd_label", 64'(bus.label), 64'(e.l));
      end
    end
  end

  task automatic issue();
    bit rd;
    bit cnt;
    int a;
    rd_t e;
    rd = bus.rd_en;
    if (bus.rd_en) begin
      a = int'(bus.raddr);
      if (a < N) begin
        e.x = CW'(mx[a]); e.y = CW'(my[a]); e.z = CW'(mz[a]);
        e.l = LW'(ml[a]); e.v = mv[a];
        e.cc = mk[a]; e.cl = mv[a];
      end else begin
        e.x = '0; e.y = '0; e.z = '0; e.l = '0; e.v = 1'b0;
        e.cc = 1'b1; e.cl = 1'b1;
      end
      q.push_back(e);
    end
    cnt = 1'b0;
    a = int'(bus.waddr);
    if (bus.we && mld && a < N) begin
      cnt = !mv[a] || ml[a] != int'(bus.wlabel);
      ml[a] = int'(bus.wlabel);
      mv[a] = 1'b1;
    end
`ifdef KPS_CHANGE_CNT_EN
    if (bus.pass_clr) mch = 0;
    else if (cnt && mch < N) mch++;
`else
    mch = 0;
`endif
    if (bus.ld_valid && !mld) begin
      mx[mwp] = int'(bus.ld_x);
      my[mwp] = int'(bus.ld_y);
      mz[mwp] = int'(bus.ld_z);
      mk[mwp] = 1'b1;
      if (mwp == N-1) mld = 1'b1;
      else mwp++;
    end
    @(posedge clk);
    #1;
    chk("rvalid", 64'(bus.rvalid), 64'(rd));
    chk("loaded", 64'(bus.loaded), 64'(mld));
    chk("ld_ready", 64'(bus.ld_ready), 64'(!mld));
    chk("changes", 64'(bus.changes), 64'(mch));
    bus.rd_en    = 1'b0;
    bus.we       = 1'b0;
    bus.pass_clr = 1'b0;
    bus.ld_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_loaded", 64'(bus.loaded), 64'd0);
    chk("rst_changes", 64'(bus.changes), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_ld_ready", 64'(bus.ld_ready), 64'd1);
    chk("rst_xyz", 64'({bus.x, bus.y, bus.z}), 64'd0);
    chk("rst_label", 64'({bus.label, bus.lvalid}), 64'd0);
    mwp = 0;
    mld = 1'b0;
    mch = 0;
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load(input int v);
    bus.ld_valid = 1'b1;
    bus.ld_x = CW'(v);
    bus.ld_y = CW'(v + 1);
    bus.ld_z = CW'(v + 2);
    issue();
  endtask

  task automatic rd(input int a);
    bus.rd_en = 1'b1;
    bus.raddr = AW'(a);
    issue();
  endtask

  task automatic wr(input int a, input int l);
    bus.we = 1'b1;
    bus.waddr = AW'(a);
    bus.wlabel = LW'(l);
    issue();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_x = '0; bus.ld_y = '0; bus.ld_z = '0;
    bus.rd_en = 1'b0; bus.raddr = '0;
    bus.we = 1'b0; bus.waddr = '0; bus.wlabel = '0;
    bus.pass_clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; mz[i] = 0; ml[i] = 0;
      mv[i] = 1'b0; mk[i] = 1'b0;
    end
    #1;
    do_reset();

    for (int i = 0; i < N; i++) begin
      if (i == 20) begin
        bus.we = 1'b1; bus.waddr = '0; bus.wlabel = 3'd5;
      end
      bus.ld_valid = 1'b1;
      if (i == 5) begin
        bus.ld_x = 8'd50; bus.ld_y = 8'd50; bus.ld_z = 8'd50;
      end else begin
        bus.ld_x = CW'($urandom); bus.ld_y = CW'($urandom);
        bus.ld_z = CW'($urandom);
      end
      issue();
    end
    load(200);
    rd(40);
    rd(5);
    rd(0);

    wr(7, 2);
    wr(7, 2);
    wr(7, 4);
    bus.pass_clr = 1'b1;
    issue();

    wr(3, 1);
    bus.rd_en = 1'b1; bus.raddr = 6'd3;
    bus.we = 1'b1; bus.waddr = 6'd3; bus.wlabel = 3'd6;
    issue();
    rd(3);

    wr(45, 1);
    rd(50);
    rd(45);

    bus.pass_clr = 1'b1;
    bus.we = 1'b1; bus.waddr = 6'd9; bus.wlabel = 3'd7;
    issue();

    for (int i = 0; i < 50; i++) begin
      wr(i % N, (ml[i % N] + 1) % 8);
    end
    wr(1, ml[1]);

    for (int i = 0; i < 400; i++) begin
      bus.rd_en    = 1'($urandom_range(0, 1));
      bus.raddr    = AW'($urandom_range(0, 63));
      bus.we       = 1'($urandom_range(0, 1));
      bus.waddr    = AW'($urandom_range(0, 47));
      bus.wlabel   = LW'($urandom);
      bus.pass_clr = ($urandom_range(0, 31) == 0);
      issue();
    end

    do_reset();
    for (int i = 0; i < 10; i++) load(10 + i);
    rd(0);
    do_reset();
    load(99);
    rd(0);
    rd(1);
    rd(7);
    wr(0, 3);
    rd(0);

    repeat (3) issue();
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
